// File: rtl/oam_dma.sv
// oam_dma: sysbus initiator copying one 256-byte page into the OAM data port.
// Optional `OAMDMA_ALIGN_EN: an odd-cycle trigger adds a DUMMY so READs start on fixed parity.
module oam_dma #(
    parameter int                ADDR_N   = 16,
    parameter int                DATA_N   = 8,
    parameter logic [ADDR_N-1:0] DMA_REG  = 16'h4014,
    parameter logic [ADDR_N-1:0] DST_ADDR = 16'h2004
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_N-1:0] cpu_addr,
    input  logic [DATA_N-1:0] cpu_data,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    output logic              dma_active,
    output logic [ADDR_N-1:0] dma_addr,
    output logic              dma_we,
    output logic [DATA_N-1:0] dma_wdata,
    input  logic [DATA_N-1:0] dma_rdata
);
    // Source address is {page, idx}; idx wraps inside the page and never carries.
    localparam int IDX_N = ADDR_N - DATA_N;

    typedef enum logic [1:0] {S_IDLE, S_DUMMY, S_READ, S_WRITE} state_t;

    state_t            r_state;
    logic [DATA_N-1:0] r_page;
    logic [IDX_N-1:0]  r_idx;
    logic              r_cpu_rdy;
    logic              r_active;
    logic [ADDR_N-1:0] r_addr;
    logic              r_we;
    logic [DATA_N-1:0] r_wdata;

    logic              w_trigger;
    logic              w_last;
    logic [IDX_N-1:0]  w_idx_nxt;

    assign w_trigger = cpu_we && (cpu_addr == DMA_REG);
    assign w_last    = (r_idx == {IDX_N{1'b1}});
    assign w_idx_nxt = r_idx + IDX_N'(1);

    assign cpu_rdy    = r_cpu_rdy;
    assign dma_active = r_active;
    assign dma_addr   = r_addr;
    assign dma_we     = r_we;
    assign dma_wdata  = r_wdata;

`ifdef OAMDMA_ALIGN_EN
    logic r_parity;
    logic r_extra;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_parity <= 1'b0;
        else       r_parity <= ~r_parity;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_page    <= '0;
            r_idx     <= '0;
            r_cpu_rdy <= 1'b1;
            r_active  <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
`ifdef OAMDMA_ALIGN_EN
            r_extra   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page    <= cpu_data;
                        r_idx     <= '0;
                        r_state   <= S_DUMMY;
                        r_cpu_rdy <= 1'b0;
                        r_active  <= 1'b1;
                        r_addr    <= '0;
                        r_we      <= 1'b0;
`ifdef OAMDMA_ALIGN_EN
                        r_extra   <= r_parity;
`endif
                    end
                end
                S_DUMMY: begin
`ifdef OAMDMA_ALIGN_EN
                    if (r_extra) begin
                        r_extra <= 1'b0;
                    end else begin
                        r_state <= S_READ;
                        r_addr  <= {r_page, r_idx};
                    end
`else
                    r_state <= S_READ;
                    r_addr  <= {r_page, r_idx};
`endif
                end
                S_READ: begin
                    r_wdata <= dma_rdata;
                    r_addr  <= DST_ADDR;
                    r_we    <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    if (w_last) begin
                        r_state   <= S_IDLE;
                        r_cpu_rdy <= 1'b1;
                        r_active  <= 1'b0;
                        r_addr    <= '0;
                        r_wdata   <= '0;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_addr  <= {r_page, w_idx_nxt};
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sysbus initiator that copies one 256-byte page into the PPU OAM data port. It mirrors the read-only responders such as the boot ROM: it drives address and control and samples returned data, where a responder only returns data.
- Triggered by a CPU write to the DMA register. Halts the CPU through `cpu_rdy` for the whole transfer.
- Top level muxes `dma_addr`/`dma_we`/`dma_wdata` onto sysbus while `dma_active`=1.

Parameters:
- `DMA_REG`, `16'h4014`, CPU write address that starts a transfer.
- `DST_ADDR`, `16'h2004`, destination address written for every byte.
- `ADDR_N`, 16, sysbus address width.
- `DATA_N`, 8, sysbus data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  `ADDR_N`  CPU bus address, snooped.
- `cpu_data`  in  `DATA_N`  CPU write data, snooped.
- `cpu_we`  in  1  CPU write strobe.
- `cpu_rdy`  out  1  1 = CPU may run; 0 = CPU halted.
- `dma_active`  out  1  1 = DMA owns sysbus this cycle.
- `dma_addr`  out  `ADDR_N`  DMA bus address.
- `dma_we`  out  1  DMA write strobe.
- `dma_wdata`  out  `DATA_N`  DMA write data.
- `dma_rdata`  in  `DATA_N`  sysbus read data, combinational from the responder.

Behaviour:
- Reset values:
  - `cpu_rdy`=1; `dma_active`=0; `dma_we`=0; `dma_addr`=0; `dma_wdata`=0.
  - state=IDLE; page=0; idx=0; parity=0.
- Parity: a free-running 1-bit toggle every clock. A trigger cycle is "odd" when parity=1 during it.
- Trigger:
  - Condition: in IDLE, `cpu_we`=1 and `cpu_addr`==`DMA_REG` at a rising edge.
  - Action: latch page=`cpu_data`, idx=0, go to DUMMY.
  - Triggers outside IDLE are ignored. Other addresses are ignored.
- States:
  - IDLE: outputs at reset values, `cpu_rdy`=1.
  - DUMMY: `cpu_rdy`=0, `dma_active`=1, `dma_we`=0, `dma_addr`=0. Lasts 1 cycle, then READ.
  - READ:
    - Drives `dma_addr`={page,idx}, `dma_we`=0.
    - At the end of the cycle, latches `dma_rdata` into the data register. `dma_wdata` reflects it from the next cycle.
    - Next state: WRITE.
  - WRITE:
    - Drives `dma_addr`=`DST_ADDR`, `dma_we`=1, `dma_wdata`=latched byte.
    - If idx==255, go to IDLE. Otherwise idx+1 and go to READ.
- Outputs are registered. `cpu_rdy` falls in the first cycle after the trigger edge. It rises in the first cycle after the final WRITE.
- Source address is formed by concatenation only: idx wraps within the page and never carries into page. Page `8'hFF` reads `FF00`..`FFFF`.
- Transfer length without alignment: 1 DUMMY + 512 READ/WRITE = 513 halted cycles.
- Exactly 256 write strobes per transfer, in idx order 0..255.
- `dma_active` = (state != IDLE). `cpu_rdy` = !`dma_active`.
- Reset asserted mid-transfer: immediate return to IDLE and all reset values. No further writes. A partial copy is not resumed.
- A trigger on the same edge that the final WRITE completes is ignored, because state is not IDLE.

Optional Feature:
- `OAMDMA_ALIGN_EN` defined:
  - A trigger in an odd cycle inserts one extra DUMMY cycle: 2 DUMMY, 514 halted cycles total.
  - A trigger in an even cycle gives 513 halted cycles.
  - READ cycles therefore always start on a fixed parity.
- Not defined: always exactly one DUMMY cycle and 513 halted cycles; parity is unused.

Test Plan:
- Reset, then write `cpu_addr`=`4014`, `cpu_data`=`02`; source model returns byte = low address byte -> 256 writes to `2004` with data `00`..`FF` in order; `cpu_rdy`=0 for exactly 513 cycles (no `OAMDMA_ALIGN_EN`).
- `OAMDMA_ALIGN_EN` defined; trigger once in an even cycle and once in an odd cycle -> halted 513 and 514 cycles respectively; first READ of both transfers at the same parity.
- Page `FF` with source data = ~low byte -> READ addresses `FF00`..`FFFF`, no carry; write data `FF`..`00`; `dma_addr` never `0000` during READ.
- Write to `4014` during an active transfer (forced `cpu_we`) -> ignored; transfer completes unchanged; still 256 writes.
- Assert `reset` after the 100th WRITE -> next cycle `cpu_rdy`=1, `dma_active`=0, `dma_we`=0; no more writes; a new trigger afterward runs a full 256-byte transfer.
- Writes to `4013`/`4015` and reads at `4014` -> no transfer; `cpu_rdy` stays 1.
